// File: rtl/dvp_cfg_pkg.sv
// Shared types and constants for the DVP camera configuration sequencer.
package dvp_cfg_pkg;

  typedef struct packed {
    logic [15:0] cfg_reg;
    logic [7:0]  val;
  } cfg_entry_t;

  localparam logic [15:0] CFG_REG_END   = 16'hFFFE;
  localparam logic [15:0] CFG_REG_DELAY = 16'hFFFF;

  typedef enum logic [3:0] {
    StIdle,
    StFetch,
    StDecode,
    StIssue,
    StWaitRsp,
    StDelay,
    StGap,
    StDone,
    StError
  } cfg_state_e;

endpackage

// File: rtl/ms_tick.sv
// Millisecond strobe: one-cycle tick every CLK_HZ/1000 enabled cycles, restarts when disabled.
module ms_tick #(
  parameter int unsigned CLK_HZ = 27_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  localparam int unsigned Div = (CLK_HZ / 1000 > 0) ? CLK_HZ / 1000 : 1;
  localparam int unsigned Cw  = (Div > 1) ? $clog2(Div) : 1;

  logic [Cw-1:0] cnt_q, cnt_d;

  assign tick = enable && (cnt_q == Cw'(Div - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (!enable || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dvp_cfg_seq.sv
// Walks an external register table and issues SCCB writes, with ms delays, retries and end marker.
module dvp_cfg_seq
  import dvp_cfg_pkg::*;
#(
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned CLK_HZ    = 27_000_000,
  parameter int unsigned MAX_TRIES = 3,
  parameter int unsigned RETRY_GAP = 2700,
  localparam int unsigned Aw       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic [Aw-1:0] tbl_addr,
  input  logic [23:0]   tbl_data,
  output logic          wr_valid,
  input  logic          wr_ready,
  output logic [15:0]   wr_reg,
  output logic [7:0]    wr_val,
  input  logic          rsp_valid,
  input  logic          rsp_nack,
  output logic          done,
  output logic          error,
  output logic [Aw-1:0] err_index
);

  localparam int unsigned Tw = $clog2(MAX_TRIES + 1);
  localparam int unsigned Gw = (RETRY_GAP > 1) ? $clog2(RETRY_GAP) : 1;

  cfg_state_e    state_q, state_d;
  logic [Aw-1:0] index_q, index_d;
  logic [Aw-1:0] err_index_q, err_index_d;
  logic [Tw-1:0] tries_q, tries_d;
  logic [Gw-1:0] gap_q, gap_d;
  logic [7:0]    ms_left_q, ms_left_d;
  logic [15:0]   wr_reg_q, wr_reg_d;
  logic [7:0]    wr_val_q, wr_val_d;
  logic          advance;
  logic          ms_strobe;
  cfg_entry_t    entry;

  assign entry = cfg_entry_t'(tbl_data);

  ms_tick #(
    .CLK_HZ(CLK_HZ)
  ) u_ms_tick (
    .clk   (clk),
    .rst   (rst),
    .enable(state_q == StDelay),
    .tick  (ms_strobe)
  );

  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    err_index_d = err_index_q;
    tries_d     = tries_q;
    gap_d       = gap_q;
    ms_left_d   = ms_left_q;
    wr_reg_d    = wr_reg_q;
    wr_val_d    = wr_val_q;
    advance     = 1'b0;

    unique case (state_q)
      StIdle, StDone, StError: begin
        if (start) begin
          index_d = '0;
          tries_d = '0;
          state_d = StFetch;
        end
      end
      StFetch: state_d = StDecode;
      StDecode: begin
        if (entry.cfg_reg == CFG_REG_END) begin
          state_d = StDone;
        end else if (entry.cfg_reg == CFG_REG_DELAY) begin
          if (entry.val == 8'd0) begin
            advance = 1'b1;
          end else begin
            ms_left_d = entry.val;
            state_d   = StDelay;
          end
        end else begin
          wr_reg_d = entry.cfg_reg;
          wr_val_d = entry.val;
          state_d  = StIssue;
        end
      end
      StIssue: begin
        if (wr_ready) state_d = StWaitRsp;
      end
      StWaitRsp: begin
        if (rsp_valid && !rsp_nack) begin
          advance = 1'b1;
        end else if (rsp_valid) begin
          tries_d = tries_q + 1'b1;
          if (tries_q + 1'b1 >= Tw'(MAX_TRIES)) begin
            err_index_d = index_q;
            state_d     = StError;
          end else if (RETRY_GAP == 0) begin
            state_d = StIssue;
          end else begin
            gap_d   = '0;
            state_d = StGap;
          end
        end
      end
      StGap: begin
        if (gap_q == Gw'(RETRY_GAP - 1)) begin
          state_d = StIssue;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      StDelay: begin
        if (ms_strobe) begin
          if (ms_left_q == 8'd1) begin
            advance = 1'b1;
          end else begin
            ms_left_d = ms_left_q - 8'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // The table ends at the last entry; no wrap back to index 0.
    if (advance) begin
      tries_d = '0;
      if (index_q == Aw'(DEPTH - 1)) begin
        state_d = StDone;
      end else begin
        index_d = index_q + 1'b1;
        state_d = StFetch;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      index_q     <= '0;
      err_index_q <= '0;
      tries_q     <= '0;
      gap_q       <= '0;
      ms_left_q   <= '0;
      wr_reg_q    <= '0;
      wr_val_q    <= '0;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      err_index_q <= err_index_d;
      tries_q     <= tries_d;
      gap_q       <= gap_d;
      ms_left_q   <= ms_left_d;
      wr_reg_q    <= wr_reg_d;
      wr_val_q    <= wr_val_d;
    end
  end

  always_comb begin
    busy      = !(state_q inside {StIdle, StDone, StError});
    done      = (state_q == StDone);
    error     = (state_q == StError);
    wr_valid  = (state_q == StIssue);
    tbl_addr  = index_q;
    err_index = err_index_q;
    wr_reg    = wr_reg_q;
    wr_val    = wr_val_q;
  end

endmodule

// File: tb/tb_dvp_cfg_seq.sv
// Directed bench for dvp_cfg_seq: ACK/NACK slave, delays, stalls, ignored start and reset.
module tb_dvp_cfg_seq;

  localparam int unsigned Aw = 4;

  logic          clk;
  logic          rst;
  logic          start;
  logic          busy;
  logic [Aw-1:0] tbl_addr;
  logic [23:0]   tbl_data;
  logic          wr_valid;
  logic          wr_ready;
  logic [15:0]   wr_reg;
  logic [7:0]    wr_val;
  logic          rsp_valid;
  logic          rsp_nack;
  logic          done;
  logic          error;
  logic [Aw-1:0] err_index;

  logic [23:0] tbl [16];
  int checks = 0;
  int errors = 0;

  dvp_cfg_seq #(
    .DEPTH    (16),
    .CLK_HZ   (1000),
    .MAX_TRIES(3),
    .RETRY_GAP(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .busy     (busy),
    .tbl_addr (tbl_addr),
    .tbl_data (tbl_data),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_reg   (wr_reg),
    .wr_val   (wr_val),
    .rsp_valid(rsp_valid),
    .rsp_nack (rsp_nack),
    .done     (done),
    .error    (error),
    .err_index(err_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read table, one cycle latency.
  always @(posedge clk) tbl_data <= tbl[tbl_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_end();
    for (int i = 0; i < 16; i++) tbl[i] = 24'hFFFE00;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_rsp(input logic nack);
    rsp_valid = 1'b1;
    rsp_nack  = nack;
    tick();
    rsp_valid = 1'b0;
    rsp_nack  = 1'b0;
  endtask

  task automatic wait_wr(output int n);
    n = 0;
    while (wr_valid !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) n = -1;
  endtask

  task automatic wait_end(output int writes);
    int n;
    n = 0;
    writes = 0;
    while (!(done === 1'b1 || error === 1'b1) && n < 100) begin
      tick();
      n++;
      if (wr_valid === 1'b1) writes++;
    end
    check("end_reached", 32'(n < 100), 32'd1);
  endtask

  initial begin
    int n;
    int writes;
    logic stable;
    logic [15:0] r0;
    logic [7:0] v0;

    rst = 1'b1; start = 1'b0; wr_ready = 1'b1; rsp_valid = 1'b0; rsp_nack = 1'b0;
    fill_end();
    tick();
    tick();
    rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_wr_valid", wr_valid, 0);
    check("rst_tbl_addr", tbl_addr, 0);
    check("rst_wr_reg", wr_reg, 0);
    for (int i = 0; i < 5; i++) tick();
    check("no_autostart", busy, 0);

    // Two writes then end marker.
    tbl[0] = 24'h300882; tbl[1] = 24'h310303; tbl[2] = 24'hFFFE00;
    pulse_start();
    check("a_busy", busy, 1);
    wait_wr(n);
    check("a_lat0", n, 2);
    check("a_reg0", wr_reg, 16'h3008);
    check("a_val0", wr_val, 8'h82);
    tick();
    check("a_wrv_drop", wr_valid, 0);
    pulse_rsp(1'b0);
    wait_wr(n);
    check("a_lat1", n, 2);
    check("a_reg1", wr_reg, 16'h3103);
    check("a_val1", wr_val, 8'h03);
    tick();
    pulse_rsp(1'b0);
    wait_end(writes);
    check("a_writes", writes, 0);
    check("a_done", done, 1);
    check("a_error", error, 0);
    check("a_busy_end", busy, 0);
    check("a_addr_end", tbl_addr, 2);

    // NACK twice on entry 1, then 5 ms delay entry.
    fill_end();
    tbl[0] = 24'h300101; tbl[1] = 24'h300202; tbl[2] = 24'hFFFF05; tbl[3] = 24'h300303;
    pulse_start();
    check("b_done_clr", done, 0);
    wait_wr(n);
    check("b_reg0", wr_reg, 16'h3001);
    tick();
    pulse_rsp(1'b0);
    wait_wr(n);
    check("b_reg1", wr_reg, 16'h3002);
    for (int t = 0; t < 2; t++) begin
      tick();
      pulse_rsp(1'b1);
      wait_wr(n);
      check("b_gap_lat", n, 4);
      check("b_retry_reg", wr_reg, 16'h3002);
      check("b_retry_val", wr_val, 8'h02);
    end
    check("b_no_err", error, 0);
    tick();
    pulse_rsp(1'b0);
    // FETCH + DECODE + 5 DELAY + FETCH + DECODE before ISSUE.
    wait_wr(n);
    check("b_delay_lat", n, 9);
    check("b_reg3", wr_reg, 16'h3003);
    tick();
    pulse_rsp(1'b0);
    wait_end(writes);
    check("b_done", done, 1);
    check("b_error", error, 0);

    // Stall, ignored start, NACK x3 on entry 2.
    fill_end();
    tbl[0] = 24'h120011; tbl[1] = 24'h120122; tbl[2] = 24'h120233;
    wr_ready = 1'b0;
    pulse_start();
    wait_wr(n);
    check("c_reg0", wr_reg, 16'h1200);
    r0 = wr_reg; v0 = wr_val; stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      start = (i == 4);
      tick();
      if (wr_valid !== 1'b1 || wr_reg !== r0 || wr_val !== v0) stable = 1'b0;
    end
    start = 1'b0;
    check("c_stall_stable", stable, 1);
    wr_ready = 1'b1;
    tick();
    check("c_accepted", wr_valid, 0);
    pulse_rsp(1'b0);
    wait_wr(n);
    check("c_reg1", wr_reg, 16'h1201);
    tick();
    pulse_start();
    pulse_rsp(1'b0);
    wait_wr(n);
    check("c_start_ignored", wr_reg, 16'h1202);
    for (int t = 0; t < 3; t++) begin
      tick();
      pulse_rsp(1'b1);
      if (t < 2) wait_wr(n);
    end
    check("c_error", error, 1);
    check("c_done", done, 0);
    check("c_err_index", err_index, 2);
    check("c_busy", busy, 0);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (wr_valid !== 1'b0) stable = 1'b0;
    end
    check("c_no_more_wr", stable, 1);

    // Restart from ERROR, then reset while waiting for a response.
    pulse_start();
    check("d_err_clr", error, 0);
    check("d_busy", busy, 1);
    wait_wr(n);
    check("d_reg0", wr_reg, 16'h1200);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("d_rst_busy", busy, 0);
    check("d_rst_err_index", err_index, 0);
    check("d_rst_wr_reg", wr_reg, 0);
    check("d_rst_wr_val", wr_val, 0);
    pulse_rsp(1'b0);
    for (int i = 0; i < 3; i++) tick();
    check("d_late_busy", busy, 0);
    check("d_late_addr", tbl_addr, 0);
    check("d_late_done", done, 0);
    check("d_late_wrv", wr_valid, 0);

    // No end marker: zero delays run to the last entry, then DONE.
    for (int i = 0; i < 16; i++) tbl[i] = 24'hFFFF00;
    pulse_start();
    wait_end(writes);
    check("e_writes", writes, 0);
    check("e_done", done, 1);
    check("e_last_addr", tbl_addr, 15);
    check("e_error", error, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dvp_cfg_seq.md
DVP_CFG_SEQ -- requirements
Module: dvp_cfg_seq

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning number of configuration table entries.
REQ-002 SHALL have parameter CLK_HZ, default 27_000_000, meaning clk frequency used for millisecond delays.
REQ-003 SHALL have parameter MAX_TRIES, default 3, meaning write attempts per entry before error.
REQ-004 SHALL have parameter RETRY_GAP, default 2700, meaning idle clk cycles between a NACK and the re-issue.
REQ-005 SHALL have ports: clk  in  1  sole clock; rst  in  1  synchronous active-high reset.
REQ-006 SHALL have ports: start  in  1  one-cycle request to run the table; busy  out  1  sequence in progress.
REQ-007 SHALL have ports: tbl_addr  out  $clog2(DEPTH)  table index; tbl_data  in  24  entry {reg[15:0], val[7:0]}.
REQ-008 SHALL have ports: wr_valid  out  1; wr_ready  in  1; wr_reg  out  16; wr_val  out  8  write request to the SCCB master.
REQ-009 SHALL have ports: rsp_valid  in  1  write finished; rsp_nack  in  1  qualified by rsp_valid, slave did not ACK.
REQ-010 SHALL have ports: done  out  1  table completed; error  out  1  retries exhausted; err_index  out  $clog2(DEPTH)  failing entry.

Function
REQ-011 SHALL implement states IDLE, FETCH, DECODE, ISSUE, WAIT_RSP, DELAY, GAP, DONE, ERROR.
REQ-012 SHALL treat the table as synchronous read with 1-cycle latency: tbl_addr is driven in FETCH, tbl_data sampled in DECODE.
REQ-013 SHALL in IDLE, DONE or ERROR, on start=1, clear done/error, set index 0, enter FETCH next cycle.
REQ-014 SHALL ignore start while busy=1; busy SHALL be 1 in every state except IDLE, DONE, ERROR.
REQ-015 SHALL decode reg 16'hFFFE as end marker: DECODE -> DONE, no write issued.
REQ-016 SHALL decode reg 16'hFFFF as delay: wait val x (CLK_HZ/1000) cycles in DELAY, then advance; val=0 advances without entering DELAY.
REQ-017 SHALL otherwise enter ISSUE with wr_valid=1 and wr_reg/wr_val held stable until the cycle wr_valid&wr_ready=1, then WAIT_RSP.
REQ-018 SHALL in WAIT_RSP on rsp_valid&!rsp_nack advance; on rsp_valid&rsp_nack increment try count.
REQ-019 SHALL after a NACK with tries<MAX_TRIES enter GAP for RETRY_GAP cycles, then ISSUE with the same entry; on tries=MAX_TRIES enter ERROR, err_index=index.
REQ-020 SHALL "advance" as: tries cleared; if index=DEPTH-1 go DONE, else index+1 and FETCH (no wrap to 0).
REQ-021 SHALL ignore rsp_valid in every state except WAIT_RSP.
REQ-022 SHALL hold done=1 in DONE and error=1 in ERROR until the next accepted start; done and error never both 1.
REQ-023 SHALL deassert wr_valid in every state except ISSUE.

Reset
REQ-024 SHALL on rst=1 at a clk edge enter IDLE: busy=0, done=0, error=0, wr_valid=0, tbl_addr=0, err_index=0, wr_reg=0, wr_val=0, counters 0.
REQ-025 SHALL abandon any in-progress sequence on reset; an in-flight SCCB transfer is not aborted and its later rsp_valid is ignored.
REQ-026 SHALL NOT auto-start after reset; start is required.

Structure
REQ-027 SHALL place in shared package dvp_cfg_pkg: entry struct {reg, val}, constants CFG_REG_END=16'hFFFE and CFG_REG_DELAY=16'hFFFF, state enum.
REQ-028 SHALL instantiate one sub-module ms_tick (CLK_HZ parameter, enable input, one-cycle tick per millisecond) for DELAY timing.
REQ-029 SHALL keep table storage outside this block.

Verification
REQ-030 Table {3008:82, 3103:03, FFFE:00}, slave always ACK -> exactly 2 writes in order, done=1, error=0.
REQ-031 Entry FFFF:05 with CLK_HZ=1000 -> 5 clk cycles (+/-1) between prior rsp_valid and next FETCH.
REQ-032 Entry 1 NACKed twice then ACKed, MAX_TRIES=3 -> 3 issues of entry 1, each after RETRY_GAP cycles, done=1.
REQ-033 Entry 2 NACKed 3 times -> error=1, err_index=2, done=0, no further wr_valid.
REQ-034 wr_ready held 0 for 10 cycles -> wr_valid and wr_reg/wr_val stable all 10; start pulsed mid-run -> ignored.
REQ-035 rst asserted during WAIT_RSP, then late rsp_valid -> outputs at reset values, state IDLE, no advance.
